// File: rtl/ifetch_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_pkg
//   Shared definitions for the instruction-fetch controller: width defaults,
//   the IF/ID bubble word and the fetch FSM state encoding.
// ----------------------------------------------------------------------------
package ifetch_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          DATA_W_DEF   = 32;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

    // IDLE  : waiting for the CPU run enable
    // ISSUE : latch the PC, request goes out next cycle
    // WAIT  : request outstanding, result still wanted
    // HELD  : response parked in the hold buffer while decode is stalled
    // DROP  : request outstanding, result squashed by a flush
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HELD  = 3'd3,
        ST_DROP  = 3'd4
    } state_t;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// ifetch_ctrl_if
//   Instruction-memory read channel (req/ack).
//     req  : read request, held until ack
//     addr : read address, stable while req is high
//     ack  : read complete, data valid in this cycle
//     data : instruction word
//   master : fetch controller side
//   slave  : instruction memory side
// ----------------------------------------------------------------------------
interface ifetch_ctrl_if
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [DATA_W-1:0] data;

    modport master (output req, addr, input  ack, data);
    modport slave  (input  req, addr, output ack, data);

endinterface

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
//   Generic pipeline register with flush > stall > load priority.
//     clk, rst_n     : clock, asynchronous active-low reset
//     flush          : replace contents with a bubble (NOP, tag 0, invalid)
//     stall          : hold data, tag and valid
//     load           : capture load_data/load_tag and mark valid
//     load_data/tag  : incoming payload and its tag (e.g. the PC)
//     data/tag/valid : register contents
//   With none of flush/stall/load active the payload is kept but valid
//   drops, so each load presents exactly one valid cycle downstream.
// ----------------------------------------------------------------------------
module if_id_reg #(
    parameter int               DATA_W = 32,
    parameter int               TAG_W  = 32,
    parameter logic [DATA_W-1:0] NOP   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              stall,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [TAG_W-1:0]  load_tag,
    output logic [DATA_W-1:0] data,
    output logic [TAG_W-1:0]  tag,
    output logic              valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= NOP;
            tag   <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            data  <= NOP;
            tag   <= '0;
            valid <= 1'b0;
        end else if (stall) begin
            data  <= data;
            tag   <= tag;
            valid <= valid;
        end else if (load) begin
            data  <= load_data;
            tag   <= load_tag;
            valid <= 1'b1;
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// ----------------------------------------------------------------------------
// ifetch_ctrl
//   Instruction-fetch controller between the PC register and a
//   variable-latency instruction memory.
//     clk_i, rst_i  : clock, asynchronous active-low reset
//     start_i       : CPU run enable, only looked at in IDLE
//     pc_i          : PC register output, latched in ISSUE
//     flush_i       : branch/jump taken; squash fetch and IF/ID
//     stall_i       : decode stall; IF/ID holds
//     stall_o       : PC freeze request (combinational)
//     mem           : instruction memory read channel (master)
//     inst_o        : IF/ID instruction
//     inst_pc_o     : IF/ID PC of inst_o
//     inst_valid_o  : IF/ID holds a real instruction
//   A one-entry hold buffer parks a response that arrives while decode is
//   stalled. A flush with no ack outstanding moves to DROP so the late ack
//   of the squashed request is swallowed rather than loaded.
// ----------------------------------------------------------------------------
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    input  logic              stall_i,
    output logic              stall_o,
    ifetch_ctrl_if.master     mem,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o
);

    state_t            st, st_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] hold_data;
    logic              load;
    logic              capture;
    logic [DATA_W-1:0] load_data;

    // ---------------------------------------------------------------
    // State, fetch address and hold buffer
    // ---------------------------------------------------------------
    // addr_q only changes in ISSUE, so in HELD it still names the parked
    // word; the hold buffer therefore needs to store just the data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            st        <= ST_IDLE;
            addr_q    <= '0;
            hold_data <= '0;
        end else begin
            st <= st_nxt;
            if (st == ST_ISSUE) addr_q    <= pc_i;
            if (capture)        hold_data <= mem.data;
        end
    end

    // ---------------------------------------------------------------
    // Next state, load/capture strobes and PC freeze
    // ---------------------------------------------------------------
    always_comb begin
        st_nxt  = st;
        load    = 1'b0;
        capture = 1'b0;
        stall_o = 1'b1;
        case (st)
            ST_IDLE: begin
                if (start_i) st_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                // A flush here means pc_i is about to become the target;
                // re-latch it next cycle instead of fetching the old PC.
                if (!flush_i) st_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem.ack) begin
                    if (flush_i) begin
                        st_nxt = ST_ISSUE;
                    end else if (stall_i) begin
                        capture = 1'b1;
                        st_nxt  = ST_HELD;
                    end else begin
                        load    = 1'b1;
                        stall_o = 1'b0;
                        st_nxt  = ST_ISSUE;
                    end
                end else if (flush_i) begin
                    st_nxt = ST_DROP;
                end
            end
            ST_HELD: begin
                if (flush_i) begin
                    st_nxt = ST_ISSUE;
                end else if (!stall_i) begin
                    load    = 1'b1;
                    stall_o = 1'b0;
                    st_nxt  = ST_ISSUE;
                end
            end
            ST_DROP: begin
                // Request must stay up until ack; the data is thrown away.
                if (mem.ack) st_nxt = ST_ISSUE;
            end
            default: begin
                st_nxt = ST_IDLE;
            end
        endcase
        // Let the PC take the branch target regardless of fetch state.
        if (flush_i) stall_o = 1'b0;
    end

    // ---------------------------------------------------------------
    // Memory channel
    // ---------------------------------------------------------------
    assign mem.req  = (st == ST_WAIT) || (st == ST_DROP);
    assign mem.addr = addr_q;

    assign load_data = (st == ST_HELD) ? hold_data : mem.data;

    // ---------------------------------------------------------------
    // IF/ID pipeline register
    // ---------------------------------------------------------------
    if_id_reg #(
        .DATA_W (DATA_W),
        .TAG_W  (ADDR_W),
        .NOP    (NOP_WORD)
    ) u_if_id (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .flush     (flush_i),
        .stall     (stall_i),
        .load      (load),
        .load_data (load_data),
        .load_tag  (addr_q),
        .data      (inst_o),
        .tag       (inst_pc_o),
        .valid     (inst_valid_o)
    );

endmodule

// File: tb/tb_ifetch_ctrl.sv
module tb_ifetch_ctrl;
    import ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] pc;
    logic        flush;
    logic        stall;
    logic        dut_stall;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;

    ifetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    ifetch_ctrl #(.ADDR_W(32), .DATA_W(32), .NOP_WORD(32'h0000_0000)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .pc_i         (pc),
        .flush_i      (flush),
        .stall_i      (stall),
        .stall_o      (dut_stall),
        .mem          (mem_bus),
        .inst_o       (inst),
        .inst_pc_o    (inst_pc),
        .inst_valid_o (inst_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] p, input logic [31:0] d);
        exp_t e;
        e.pc   = p;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every valid IF/ID cycle must match the oldest expected load.
    always @(negedge clk) begin
        if (rst === 1'b1 && inst_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_load: got pc %h inst %h, expected no load", inst_pc, inst);
            end else begin
                mon_e = exp_q.pop_front();
                chk("load_pc",   inst_pc, mon_e.pc);
                chk("load_inst", inst,    mon_e.data);
            end
        end
    end

    // Apply this cycle's inputs (just after a rising edge) and settle.
    task automatic drive(input logic a, input logic [31:0] d, input logic f, input logic s);
        mem_bus.ack  = a;
        mem_bus.data = d;
        flush        = f;
        stall        = s;
        #1;
    endtask

    // Finish the cycle; the bench plays the PC register.
    task automatic tick(input logic [31:0] tgt);
        logic s;
        s = dut_stall;
        @(posedge clk);
        #1;
        if (!s) pc = flush ? tgt : pc + 32'd4;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pc = '0; flush = 1'b0; stall = 1'b0;
        mem_bus.ack = 1'b0; mem_bus.data = '0;
        #1 rst = 1'b0;
        #1;
        chk("rst_req",   32'(mem_bus.req), 32'd0);
        chk("rst_addr",  mem_bus.addr,     32'd0);
        chk("rst_inst",  inst,             32'd0);
        chk("rst_ipc",   inst_pc,          32'd0);
        chk("rst_valid", 32'(inst_valid),  32'd0);
        chk("rst_stall", 32'(dut_stall),   32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // idle without start: nothing happens
        drive(0, 0, 0, 0);
        chk("idle_req", 32'(mem_bus.req), 32'd0);
        tick(0);

        // ---- zero-wait memory, PC 0,4,8 ----
        start = 1'b1; drive(0, 0, 0, 0); tick(0); start = 1'b0;
        drive(0, 0, 0, 0);
        chk("zw_issue_req",   32'(mem_bus.req), 32'd0);
        chk("zw_issue_stall", 32'(dut_stall),   32'd1);
        tick(0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h1000 + pc, 0, 0);
            chk("zw_addr",  mem_bus.addr,    32'(i * 4));
            chk("zw_stall", 32'(dut_stall),  32'd0);
            chk("zw_valid", 32'(inst_valid), 32'd0);
            push_exp(32'(i * 4), 32'h1000 + 32'(i * 4));
            tick(0);
            if (i < 2) begin
                drive(0, 0, 0, 0);
                chk("zw_issue_stall", 32'(dut_stall), 32'd1);
                tick(0);
            end
        end

        // ---- 3-cycle latency at 0x40 ----
        pc = 32'h40;
        drive(0, 0, 0, 0); tick(0);
        for (int c = 0; c < 3; c++) begin
            drive(c == 2, 32'h1040, 0, 0);
            chk("lat_req",  32'(mem_bus.req), 32'd1);
            chk("lat_addr", mem_bus.addr,     32'h40);
            if (c < 2) chk("lat_stall", 32'(dut_stall), 32'd1);
            else begin
                chk("lat_ack_stall", 32'(dut_stall), 32'd0);
                push_exp(32'h40, 32'h1040);
            end
            tick(0);
        end

        // ---- flush during WAIT for 0x20, target 0x80 ----
        pc = 32'h20;
        drive(0, 0, 0, 0); tick(0);
        drive(0, 0, 0, 0);
        chk("fl_addr", mem_bus.addr, 32'h20);
        tick(0);
        drive(0, 0, 1, 0);
        chk("fl_stall", 32'(dut_stall), 32'd0);
        tick(32'h80);
        drive(0, 0, 0, 0);
        chk("drop_req",   32'(mem_bus.req), 32'd1);
        chk("drop_addr",  mem_bus.addr,     32'h20);
        chk("drop_stall", 32'(dut_stall),   32'd1);
        chk("drop_valid", 32'(inst_valid),  32'd0);
        chk("drop_inst",  inst,             32'd0);
        tick(0);
        drive(1, 32'hDEAD, 0, 0);
        chk("drop_ack_stall", 32'(dut_stall), 32'd1);
        tick(0);
        drive(0, 0, 0, 0);
        chk("post_drop_req",   32'(mem_bus.req), 32'd0);
        chk("post_drop_valid", 32'(inst_valid),  32'd0);
        tick(0);
        drive(1, 32'h1080, 0, 0);
        chk("target_addr", mem_bus.addr, 32'h80);
        push_exp(32'h80, 32'h1080);
        tick(0);

        // ---- stall at ack for 0x10, held 4 cycles ----
        pc = 32'h10;
        drive(0, 0, 0, 0); tick(0);
        drive(1, 32'hBEEF, 0, 1);
        chk("st_addr",  mem_bus.addr,   32'h10);
        chk("st_stall", 32'(dut_stall), 32'd1);
        tick(0);
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 1);
            chk("held_req",   32'(mem_bus.req), 32'd0);
            chk("held_stall", 32'(dut_stall),   32'd1);
            chk("held_valid", 32'(inst_valid),  32'd0);
            chk("held_inst",  inst,             32'h1080);
            chk("held_ipc",   inst_pc,          32'h80);
            tick(0);
        end
        drive(0, 0, 0, 0);
        chk("release_stall", 32'(dut_stall), 32'd0);
        push_exp(32'h10, 32'hBEEF);
        tick(0);
        drive(0, 0, 0, 0);
        chk("after_release_stall", 32'(dut_stall), 32'd1);
        tick(0);

        // ---- ack + flush + stall together ----
        drive(1, 32'h5555, 1, 1);
        chk("sim_addr",  mem_bus.addr,   32'h14);
        chk("sim_stall", 32'(dut_stall), 32'd0);
        tick(32'h100);
        drive(0, 0, 0, 0);
        chk("sim_valid", 32'(inst_valid),  32'd0);
        chk("sim_inst",  inst,             32'd0);
        chk("sim_ipc",   inst_pc,          32'd0);
        chk("sim_req",   32'(mem_bus.req), 32'd0);
        tick(0);
        drive(1, 32'h1100, 0, 0);
        chk("sim_next_addr", mem_bus.addr, 32'h100);
        push_exp(32'h100, 32'h1100);
        tick(0);

        // ---- reset mid-WAIT ----
        drive(0, 0, 0, 0); tick(0);
        drive(0, 0, 0, 0);
        chk("pre_rst_req",  32'(mem_bus.req), 32'd1);
        chk("pre_rst_addr", mem_bus.addr,     32'h104);
        chk("pre_rst_inst", inst,             32'h1100);
        rst = 1'b0;
        #1;
        chk("mrst_req",   32'(mem_bus.req), 32'd0);
        chk("mrst_addr",  mem_bus.addr,     32'd0);
        chk("mrst_inst",  inst,             32'd0);
        chk("mrst_ipc",   inst_pc,          32'd0);
        chk("mrst_valid", 32'(inst_valid),  32'd0);
        chk("mrst_stall", 32'(dut_stall),   32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 32'hBAD0, 0, 0);
        chk("stale_ack_req", 32'(mem_bus.req), 32'd0);
        tick(0);
        drive(0, 0, 0, 0);
        chk("nostart_req",   32'(mem_bus.req), 32'd0);
        chk("nostart_stall", 32'(dut_stall),   32'd1);
        tick(0);
        start = 1'b1; drive(0, 0, 0, 0); tick(0); start = 1'b0;
        drive(0, 0, 0, 0); tick(0);
        drive(1, 32'h1104, 0, 0);
        chk("restart_addr", mem_bus.addr, 32'h104);
        push_exp(32'h104, 32'h1104);
        tick(0);
        drive(0, 0, 0, 0); tick(0);
        tick(0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
